// File: rtl/div_sched.sv
// Round-robin sequencer in front of the shared unsigned divider: handles RV32M
// DIV/DIVU/REM/REMU, resolving divide-by-zero and signed overflow without the divider.
module div_sched #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        div_start,
  output logic        div_reset,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_ok,
  input  logic        div_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t      state, state_nx;
  logic        last;
  logic        grant_any, grant1;
  logic [1:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic        sel_signed, sel_local;
  logic [31:0] local_res, mag_a, mag_b;
  logic [1:0]  op_r;
  logic        a_neg, b_neg;
  logic [CW-1:0] cnt;
  logic        abort;
  logic        rst_pulse;
  logic [31:0] q_fix, r_fix, div_res;

  // last holds the id granted most recently; reset value 1 makes req0 win the first tie
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant1 = ~last;
    else                          grant1 = req1_valid;
  end

  assign req0_ready = (state == IDLE) & grant_any & ~grant1;
  assign req1_ready = (state == IDLE) & grant1;

  always_comb begin
    sel_op     = grant1 ? req1_op : req0_op;
    sel_a      = grant1 ? req1_a  : req0_a;
    sel_b      = grant1 ? req1_b  : req0_b;
    sel_signed = ~sel_op[0];
    sel_local  = (sel_b == '0) ||
                 (sel_signed && sel_a == 32'h8000_0000 && sel_b == '1);
    if (sel_b == '0) local_res = sel_op[1] ? sel_a : '1;
    else             local_res = sel_op[1] ? '0 : 32'h8000_0000;
    mag_a = (sel_signed && sel_a[31]) ? -sel_a : sel_a;
    mag_b = (sel_signed && sel_b[31]) ? -sel_b : sel_b;
  end

  always_comb begin
    q_fix   = (~op_r[0] && (a_neg ^ b_neg)) ? -div_q : div_q;
    r_fix   = (~op_r[0] && a_neg) ? -div_r : div_r;
    div_res = op_r[1] ? r_fix : q_fix;
  end

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      IDLE: if (grant_any) state_nx = sel_local ? RESP : RUN;
      RUN: begin
        if (div_ok) begin
          state_nx = RESP;
        end else if (div_err || cnt == CW'(TIMEOUT - 1)) begin
          state_nx = RESP;
          abort    = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      resp_id   <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      op_r      <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      cnt       <= '0;
      rst_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      rst_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            last     <= grant1;
            resp_id  <= grant1;
            resp_err <= 1'b0;
            op_r     <= sel_op;
            a_neg    <= sel_a[31];
            b_neg    <= sel_b[31];
            cnt      <= '0;
            if (sel_local) begin
              resp_data <= local_res;
            end else begin
              div_a <= mag_a;
              div_b <= mag_b;
            end
          end
        end
        RUN: begin
          if (div_ok) begin
            resp_data <= div_res;
          end else if (abort) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            rst_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign div_start  = (state == RUN);
  assign div_reset  = reset | rst_pulse;

endmodule
